// File: rtl/conv_window_addr_gen_if.sv
// -----------------------------------------------------------------------------
// conv_window_addr_gen_if
// Address stream between the window address generator and the pixel-memory
// read port. The generator drives the master side and the memory reader
// consumes it through the slave side.
//
// Signals:
//   addr_valid  master -> slave  address is valid this cycle
//   address     master -> slave  pixel-memory read address (ADDR_SIZE bits)
//   win_last    master -> slave  address is the last tap of its window
//   ready_in    slave -> master  consumer accepts the current address
// -----------------------------------------------------------------------------
interface conv_window_addr_gen_if #(
  parameter int ADDR_SIZE = 8
);

  logic                 addr_valid;
  logic [ADDR_SIZE-1:0] address;
  logic                 win_last;
  logic                 ready_in;

  modport master (
    output addr_valid,
    output address,
    output win_last,
    input  ready_in
  );

  modport slave (
    input  addr_valid,
    input  address,
    input  win_last,
    output ready_in
  );

endinterface

// File: rtl/conv_window_addr_gen.sv
// -----------------------------------------------------------------------------
// conv_window_addr_gen
// Walks a KERNEL_SIZE x KERNEL_SIZE window across an IMG_W x IMG_H row-major
// image with step STRIDE. One pixel address is emitted per kernel tap over a
// valid/ready handshake. Scan order is kc (fastest), kr, ox, oy. frame_done
// pulses for one cycle after the final tap has been accepted.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   start       one-cycle frame request, honoured only while idle
//   base_addr   (only with CONV_ADDR_BASE_OFFSET_EN) offset added to every
//               address, sampled on the start cycle
//   frame_done  one-cycle pulse at the end of a frame
//   busy        high while a frame is running or finishing
//   bus         address stream (master side): addr_valid, address,
//               win_last out; ready_in in
//
// Optional feature macro: CONV_ADDR_BASE_OFFSET_EN
// -----------------------------------------------------------------------------
module conv_window_addr_gen #(
  parameter int IMG_W       = 16,
  parameter int IMG_H       = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int ADDR_SIZE   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
`ifdef CONV_ADDR_BASE_OFFSET_EN
  input  logic [ADDR_SIZE-1:0]   base_addr,
`endif
  output logic                   frame_done,
  output logic                   busy,
  conv_window_addr_gen_if.master bus
);

  localparam int OUT_W = (IMG_W - KERNEL_SIZE) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - KERNEL_SIZE) / STRIDE + 1;

  // Counter widths never drop below one bit so degenerate sizes still elaborate.
  localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int XW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int YW = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(KERNEL_SIZE - 1);
  localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        kc_q, kc_d;
  logic [KW-1:0]        kr_q, kr_d;
  logic [XW-1:0]        ox_q, ox_d;
  logic [YW-1:0]        oy_q, oy_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 win_last_q, win_last_d;
  logic [ADDR_SIZE-1:0] offset_d;

`ifdef CONV_ADDR_BASE_OFFSET_EN
  logic [ADDR_SIZE-1:0] base_q;

  // The offset is taken from base_addr on the accepted start and frozen for
  // the rest of the frame, so the first address already includes it.
  always_comb begin
    offset_d = base_q;
    if (state_q == IDLE && start) begin
      offset_d = base_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q <= '0;
    end else begin
      base_q <= offset_d;
    end
  end
`else
  always_comb begin
    offset_d = '0;
  end
`endif

  // Next-state and counter advance. In RUN, addr_valid is always high, so a
  // handshake is simply ready_in. The counters form a mixed-radix odometer;
  // the carry out of oy marks the final tap and ends the frame.
  always_comb begin
    state_d = state_q;
    kc_d    = kc_q;
    kr_d    = kr_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          kc_d    = '0;
          kr_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
        end
      end
      RUN: begin
        if (bus.ready_in) begin
          if (kc_q != K_LAST) begin
            kc_d = kc_q + 1'b1;
          end else begin
            kc_d = '0;
            if (kr_q != K_LAST) begin
              kr_d = kr_q + 1'b1;
            end else begin
              kr_d = '0;
              if (ox_q != X_LAST) begin
                ox_d = ox_q + 1'b1;
              end else begin
                ox_d = '0;
                if (oy_q != Y_LAST) begin
                  oy_d = oy_q + 1'b1;
                end else begin
                  oy_d    = '0;
                  state_d = DONE;
                end
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The address is computed from the next counter values so the registered
  // output lines up with the counters on the same edge; with ready_in low
  // the counters hold and so does the address.
  always_comb begin
    addr_d = ADDR_SIZE'((32'(oy_d) * 32'(STRIDE) + 32'(kr_d)) * 32'(IMG_W)
                        + 32'(ox_d) * 32'(STRIDE) + 32'(kc_d)) + offset_d;
    win_last_d = (state_d == RUN) && (kc_d == K_LAST) && (kr_d == K_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      kc_q       <= '0;
      kr_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      addr_q     <= '0;
      win_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kc_q       <= kc_d;
      kr_q       <= kr_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      addr_q     <= addr_d;
      win_last_q <= win_last_d;
    end
  end

  assign bus.addr_valid = (state_q == RUN);
  assign bus.address    = addr_q;
  assign bus.win_last   = win_last_q;
  assign frame_done     = (state_q == DONE);
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_conv_window_addr_gen
// Directed bench for conv_window_addr_gen. Instance A is a 4x4 image with a
// 3x3 kernel and stride 1; instance B is a 5x5 image with a 3x3 kernel and
// stride 2. Inputs are driven and outputs sampled on the falling edge.
// With CONV_ADDR_BASE_OFFSET_EN defined, instance A also gets a base offset.
// -----------------------------------------------------------------------------
module tb_conv_window_addr_gen;

  logic clk = 1'b0;
  logic rst;
  logic startA;
  logic startB;
  logic ready;
  logic sel;
  logic frameDoneA, frameDoneB;
  logic busyA, busyB;
`ifdef CONV_ADDR_BASE_OFFSET_EN
  logic [7:0] baseA;
  logic [7:0] baseB;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_window_addr_gen_if #(.ADDR_SIZE(8)) ifA ();
  conv_window_addr_gen_if #(.ADDR_SIZE(8)) ifB ();

  assign ifA.ready_in = ready;
  assign ifB.ready_in = ready;

  conv_window_addr_gen #(
    .IMG_W(4), .IMG_H(4), .KERNEL_SIZE(3), .STRIDE(1), .ADDR_SIZE(8)
  ) dutA (
    .clk        (clk),
    .rst        (rst),
    .start      (startA),
`ifdef CONV_ADDR_BASE_OFFSET_EN
    .base_addr  (baseA),
`endif
    .frame_done (frameDoneA),
    .busy       (busyA),
    .bus        (ifA)
  );

  conv_window_addr_gen #(
    .IMG_W(5), .IMG_H(5), .KERNEL_SIZE(3), .STRIDE(2), .ADDR_SIZE(8)
  ) dutB (
    .clk        (clk),
    .rst        (rst),
    .start      (startB),
`ifdef CONV_ADDR_BASE_OFFSET_EN
    .base_addr  (baseB),
`endif
    .frame_done (frameDoneB),
    .busy       (busyB),
    .bus        (ifB)
  );

  // Observation mux so scan loops can look at either instance.
  logic       obsValid, obsLast, obsDone, obsBusy;
  logic [7:0] obsAddr;
  assign obsValid = sel ? ifB.addr_valid : ifA.addr_valid;
  assign obsLast  = sel ? ifB.win_last   : ifA.win_last;
  assign obsDone  = sel ? frameDoneB     : frameDoneA;
  assign obsBusy  = sel ? busyB          : busyA;
  assign obsAddr  = sel ? ifB.address    : ifA.address;

  // Reference address for handshake number n of a frame.
  function automatic int expAddr(int n, int w, int k, int s);
    int outW;
    int tap;
    int win;
    outW = (w - k) / s + 1;
    tap  = n % (k * k);
    win  = n / (k * k);
    return ((win / outW) * s + tap / k) * w + (win % outW) * s + tap % k;
  endfunction

  task automatic test_reset;
    rst    = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
    ready  = 1'b1;
    sel    = 1'b0;
`ifdef CONV_ADDR_BASE_OFFSET_EN
    baseA  = 8'd0;
    baseB  = 8'd0;
`endif
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ifA.addr_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", ifA.addr_valid);
    end
    checks++;
    if (ifA.address !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_address: got %0d expected 0", ifA.address);
    end
    checks++;
    if (ifA.win_last !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_win_last: got %0b expected 0", ifA.win_last);
    end
    checks++;
    if (frameDoneA !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_frame_done: got %0b expected 0", frameDoneA);
    end
    checks++;
    if (busyA !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busyA);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_scan;
    int seq[64];
    int n;
    bit done;
    int expFirst[9];
    expFirst = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    sel   = 1'b0;
    ready = 1'b1;
    n     = 0;
    done  = 1'b0;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    checks++;
    if (ifA.addr_valid !== 1'b1 || ifA.address !== 8'd0) begin
      errors++; $display("[TB] FAIL basic_first: got valid=%0b addr=%0d expected valid=1 addr=0",
                         ifA.addr_valid, ifA.address);
    end
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (obsDone) begin
        done = 1'b1;
      end else if (obsValid && n < 64) begin
        seq[n] = int'(obsAddr);
        checks++;
        if (int'(obsAddr) !== expAddr(n, 4, 3, 1)) begin
          errors++; $display("[TB] FAIL basic_addr[%0d]: got %0d expected %0d", n, obsAddr, expAddr(n, 4, 3, 1));
        end
        checks++;
        if (obsLast !== ((n % 9) == 8)) begin
          errors++; $display("[TB] FAIL basic_win_last[%0d]: got %0b expected %0b", n, obsLast, (n % 9) == 8);
        end
        n++;
      end else begin
        checks++; errors++;
        $display("[TB] FAIL basic_bubble: got valid=0 at handshake %0d expected valid=1", n);
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("[TB] FAIL basic_timeout: got no frame_done expected frame_done");
    end
    checks++;
    if (n !== 36) begin
      errors++; $display("[TB] FAIL basic_count: got %0d expected 36", n);
    end
    if (n >= 36) begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (seq[i] !== expFirst[i]) begin
          errors++; $display("[TB] FAIL basic_window0[%0d]: got %0d expected %0d", i, seq[i], expFirst[i]);
        end
      end
      checks++;
      if (seq[9] !== 1) begin
        errors++; $display("[TB] FAIL basic_window1_start: got %0d expected 1", seq[9]);
      end
      checks++;
      if (seq[18] !== 4) begin
        errors++; $display("[TB] FAIL basic_window2_start: got %0d expected 4", seq[18]);
      end
      checks++;
      if (seq[35] !== 15) begin
        errors++; $display("[TB] FAIL basic_last_addr: got %0d expected 15", seq[35]);
      end
    end
    checks++;
    if (obsValid !== 1'b0 || obsBusy !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_done_state: got valid=%0b busy=%0b expected valid=0 busy=1",
                         obsValid, obsBusy);
    end
    @(negedge clk);
    checks++;
    if (obsDone !== 1'b0 || obsBusy !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_idle_after: got done=%0b busy=%0b expected done=0 busy=0",
                         obsDone, obsBusy);
    end
  endtask

  task automatic test_stride;
    int seq[64];
    int n;
    bit done;
    sel   = 1'b1;
    ready = 1'b1;
    n     = 0;
    done  = 1'b0;
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (obsDone) begin
        done = 1'b1;
      end else if (obsValid && n < 64) begin
        seq[n] = int'(obsAddr);
        checks++;
        if (int'(obsAddr) !== expAddr(n, 5, 3, 2)) begin
          errors++; $display("[TB] FAIL stride_addr[%0d]: got %0d expected %0d", n, obsAddr, expAddr(n, 5, 3, 2));
        end
        n++;
      end else begin
        checks++; errors++;
        $display("[TB] FAIL stride_bubble: got valid=0 at handshake %0d expected valid=1", n);
      end
    end
    checks++;
    if (!done || n !== 36) begin
      errors++; $display("[TB] FAIL stride_count: got %0d handshakes done=%0b expected 36 done=1", n, done);
    end
    if (n >= 36) begin
      checks++;
      if (seq[0] !== 0 || seq[9] !== 2 || seq[18] !== 10 || seq[27] !== 12) begin
        errors++; $display("[TB] FAIL stride_window_starts: got %0d,%0d,%0d,%0d expected 0,2,10,12",
                           seq[0], seq[9], seq[18], seq[27]);
      end
      checks++;
      if (seq[35] !== 24) begin
        errors++; $display("[TB] FAIL stride_last_addr: got %0d expected 24", seq[35]);
      end
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_backpressure;
    int n;
    int stallCnt;
    bit done;
    sel      = 1'b0;
    ready    = 1'b1;
    n        = 0;
    stallCnt = 0;
    done     = 1'b0;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (obsDone) begin
        done = 1'b1;
      end else if (n == 4 && stallCnt < 3) begin
        ready = 1'b0;
        checks++;
        if (obsValid !== 1'b1 || obsAddr !== 8'd5) begin
          errors++; $display("[TB] FAIL bp_hold[%0d]: got valid=%0b addr=%0d expected valid=1 addr=5",
                             stallCnt, obsValid, obsAddr);
        end
        stallCnt++;
      end else begin
        ready = 1'b1;
        if (obsValid) begin
          checks++;
          if (int'(obsAddr) !== expAddr(n, 4, 3, 1)) begin
            errors++; $display("[TB] FAIL bp_addr[%0d]: got %0d expected %0d", n, obsAddr, expAddr(n, 4, 3, 1));
          end
          n++;
        end else begin
          checks++; errors++;
          $display("[TB] FAIL bp_bubble: got valid=0 at handshake %0d expected valid=1", n);
        end
      end
    end
    ready = 1'b1;
    checks++;
    if (!done || n !== 36 || stallCnt !== 3) begin
      errors++; $display("[TB] FAIL bp_count: got %0d handshakes stalls=%0d done=%0b expected 36 3 1",
                         n, stallCnt, done);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int n;
    int dones;
    bit done;
    sel   = 1'b0;
    ready = 1'b1;
    n     = 0;
    dones = 0;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) @(negedge clk);
      startA = (c == 10);
      if (obsDone) begin
        dones++;
      end else if (obsValid) begin
        checks++;
        if (int'(obsAddr) !== expAddr(n, 4, 3, 1)) begin
          errors++; $display("[TB] FAIL busy_start_addr[%0d]: got %0d expected %0d", n, obsAddr, expAddr(n, 4, 3, 1));
        end
        n++;
      end
    end
    startA = 1'b0;
    checks++;
    if (dones !== 1) begin
      errors++; $display("[TB] FAIL busy_start_dones: got %0d expected 1", dones);
    end
    checks++;
    if (n !== 36) begin
      errors++; $display("[TB] FAIL busy_start_count: got %0d expected 36", n);
    end
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    checks++;
    if (obsValid !== 1'b1 || obsAddr !== 8'd0) begin
      errors++; $display("[TB] FAIL busy_restart: got valid=%0b addr=%0d expected valid=1 addr=0",
                         obsValid, obsAddr);
    end
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (obsDone) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++; $display("[TB] FAIL busy_drain_timeout: got no frame_done expected frame_done");
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    int n;
    int dones;
    bit hit;
    bit done;
    sel   = 1'b0;
    ready = 1'b1;
    n     = 0;
    hit   = 1'b0;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (c > 0) @(negedge clk);
      if (obsValid && n == 20) begin
        hit = 1'b1;
        rst = 1'b0;
      end else if (obsValid) begin
        n++;
      end
    end
    checks++;
    if (!hit) begin
      errors++; $display("[TB] FAIL rst_mid_timeout: got tap %0d expected tap 20", n);
    end
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (ifA.addr_valid !== 1'b0 || ifA.address !== 8'd0 || ifA.win_last !== 1'b0 ||
        frameDoneA !== 1'b0 || busyA !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_outputs: got valid=%0b addr=%0d last=%0b done=%0b busy=%0b expected all 0",
                         ifA.addr_valid, ifA.address, ifA.win_last, frameDoneA, busyA);
    end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (frameDoneA || ifA.addr_valid) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("[TB] FAIL rst_mid_quiet: got %0d active cycles expected 0", dones);
    end
    // Reset and start in the same cycle: reset must win.
    rst    = 1'b0;
    startA = 1'b1;
    @(negedge clk);
    rst    = 1'b1;
    startA = 1'b0;
    checks++;
    if (busyA !== 1'b0 || ifA.addr_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_with_start: got busy=%0b valid=%0b expected 0 0", busyA, ifA.addr_valid);
    end
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    checks++;
    if (ifA.addr_valid !== 1'b1 || ifA.address !== 8'd0) begin
      errors++; $display("[TB] FAIL rst_fresh_start: got valid=%0b addr=%0d expected valid=1 addr=0",
                         ifA.addr_valid, ifA.address);
    end
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (frameDoneA) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++; $display("[TB] FAIL rst_drain_timeout: got no frame_done expected frame_done");
    end
    @(negedge clk);
  endtask

`ifdef CONV_ADDR_BASE_OFFSET_EN
  task automatic test_base_offset;
    int seq[64];
    int n;
    bit done;
    int expFirst[6];
    expFirst = '{250, 251, 252, 254, 255, 0};
    sel   = 1'b0;
    ready = 1'b1;
    n     = 0;
    done  = 1'b0;
    baseA = 8'd250;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    baseA  = 8'd3;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (obsDone) begin
        done = 1'b1;
      end else if (obsValid && n < 64) begin
        seq[n] = int'(obsAddr);
        checks++;
        if (int'(obsAddr) !== (expAddr(n, 4, 3, 1) + 250) % 256) begin
          errors++; $display("[TB] FAIL offset_addr[%0d]: got %0d expected %0d", n, obsAddr,
                             (expAddr(n, 4, 3, 1) + 250) % 256);
        end
        n++;
      end else begin
        checks++; errors++;
        $display("[TB] FAIL offset_bubble: got valid=0 at handshake %0d expected valid=1", n);
      end
    end
    checks++;
    if (!done || n !== 36) begin
      errors++; $display("[TB] FAIL offset_count: got %0d done=%0b expected 36 1", n, done);
    end
    if (n >= 36) begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seq[i] !== expFirst[i]) begin
          errors++; $display("[TB] FAIL offset_first[%0d]: got %0d expected %0d", i, seq[i], expFirst[i]);
        end
      end
      checks++;
      if (seq[35] !== 9) begin
        errors++; $display("[TB] FAIL offset_last: got %0d expected 9", seq[35]);
      end
    end
    baseA = 8'd0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_scan();
    test_stride();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_frame();
`ifdef CONV_ADDR_BASE_OFFSET_EN
    test_base_offset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_addr_gen.md
Name: conv_window_addr_gen

Overview:
Parametrised read-address generator for the convolution datapath. It walks a KERNEL_SIZE x KERNEL_SIZE window across an IMG_W x IMG_H image stored row-major, with a configurable stride, and emits one pixel-memory address per tap. Addresses go out over a valid/ready handshake and the block pulses a frame-done flag at the end. It supersedes the free-running 4-bit write-address counter on the image-buffer read side.

Parameters:
IMG_W, 16, image width in pixels (>= KERNEL_SIZE)
IMG_H, 16, image height in pixels (>= KERNEL_SIZE)
KERNEL_SIZE, 3, square kernel edge (>= 1)
STRIDE, 1, window step in both axes (>= 1)
ADDR_SIZE, 8, address width; must satisfy 2**ADDR_SIZE >= IMG_W*IMG_H

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-low reset
start  input  1  one-cycle request to begin a frame; ignored unless idle
ready_in  input  1  downstream accepts current address
addr_valid  output  1  address is valid
address  output  ADDR_SIZE  pixel-memory read address
win_last  output  1  current address is the last tap of its window
frame_done  output  1  one-cycle pulse after the final tap is accepted
busy  output  1  high in RUN and DONE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-low.
- Derived values: OUT_W = (IMG_W-KERNEL_SIZE)/STRIDE+1 and OUT_H = (IMG_H-KERNEL_SIZE)/STRIDE+1, both integer division.
- Internal counters: kc and kr count 0..KERNEL_SIZE-1; ox counts 0..OUT_W-1; oy counts 0..OUT_H-1.
- Output address = (oy*STRIDE+kr)*IMG_W + ox*STRIDE + kc. The value is registered and truncated to ADDR_SIZE.
- Scan order: kc is fastest, then kr, then ox, then oy.
- FSM states: IDLE, RUN, DONE.
- IDLE: addr_valid=0. When start=1, all counters clear and the state moves to RUN on the next edge. The first address (0) is presented with addr_valid=1 one cycle after start.
- RUN: a handshake is addr_valid & ready_in. Each handshake advances the counters, and the next address appears the following cycle with no bubble. Throughput is one address per cycle while ready_in=1.
- Backpressure: while addr_valid=1 and ready_in=0, address and win_last hold stable.
- win_last=1 exactly when kc=kr=KERNEL_SIZE-1.
- Wrap rules on handshake:
  - kc wraps to 0 and increments kr.
  - kr wraps and increments ox.
  - ox wraps and increments oy.
  - A handshake on the final tap (oy=OUT_H-1, ox=OUT_W-1, win_last) moves the state to DONE.
- DONE: lasts one cycle. addr_valid=0, frame_done=1, busy=1. The state then returns to IDLE with frame_done=0.
- start while in RUN or DONE is ignored; there is no restart mid-frame.
- start and reset together: reset wins.
- Reset values (also applied on a mid-frame reset): state=IDLE, all counters=0, address=0, addr_valid=0, win_last=0, frame_done=0, busy=0. A mid-frame reset discards the frame with no frame_done pulse.
- Frame length: total handshakes per frame = OUT_W*OUT_H*KERNEL_SIZE*KERNEL_SIZE.

Optional Feature:
Macro: CONV_ADDR_BASE_OFFSET_EN.
- Defined: adds port base_addr (input, ADDR_SIZE). It is sampled on the start cycle, held for the frame, and added to every address (modulo 2**ADDR_SIZE). This allows several images to share one buffer.
- Undefined: no port; the offset is zero and behaviour is exactly as above.

Test Plan:
- Basic scan, IMG 4x4, K=3, STRIDE=1, ready_in=1, pulse start: addresses 0,1,2,4,5,6,8,9,10 with win_last on 10; window 2 starts at 1, window 3 at 4; last address 15; 36 handshakes total; frame_done one cycle after the last handshake.
- Stride, IMG 5x5, K=3, STRIDE=2: window starts 0,2,10,12; final address 24; 36 handshakes.
- Backpressure, 4x4 scan: hold ready_in=0 for 3 cycles while address=5. Address stays 5 with addr_valid=1, then 6 follows; the sequence is otherwise unchanged.
- Start while busy: pulse start mid-frame. No effect; exactly one frame_done; the next start after IDLE restarts at 0.
- Reset mid-frame: assert rst low at tap 20. Next edge gives all outputs 0 and IDLE; no frame_done; a fresh start yields address 0.
- Base offset with CONV_ADDR_BASE_OFFSET_EN defined, ADDR_SIZE=8, base_addr=250, 4x4 K=3: first addresses 250,251,252,254,255,0; last address 9 (wrap-around).
